pipelined_mul_unit: RTL

Parametrised, fully pipelined integer multiply unit for the out-of-order core's MUL issue port and the vector lanes. It accepts one operation per cycle under a valid/ready handshake and carries a ROB tag alongside each operation. It supports stall backpressure and a global flush. When compiled with SIMD support, it performs packed per-element multiplies at SEW = 8/16/32/64.

---
 rtl/pipelined_mul_unit_pkg.sv | 25 ++
 rtl/pipelined_mul_unit_if.sv | 35 +++
 rtl/pipelined_mul_unit_lane_array.sv | 85 ++++++++
 rtl/pipelined_mul_unit.sv | 120 ++++++++++++
 4 files changed

// File: rtl/pipelined_mul_unit_pkg.sv
// mul_pkg: shared types for the pipelined multiply unit.
//   mul_op_e : operation encoding (MUL / MULH / MULHSU / MULHU)
//   sew_e    : element width encoding (8 / 16 / 32 / 64)
//   sew_bits : element width in bits for an sew_e value
package mul_pkg;

  typedef enum logic [1:0] {
    OP_MUL    = 2'b00,
    OP_MULH   = 2'b01,
    OP_MULHSU = 2'b10,
    OP_MULHU  = 2'b11
  } mul_op_e;

  typedef enum logic [1:0] {
    SEW_8  = 2'b00,
    SEW_16 = 2'b01,
    SEW_32 = 2'b10,
    SEW_64 = 2'b11
  } sew_e;

  function automatic int sew_bits(sew_e sew);
    return 8 << int'(sew);
  endfunction

endpackage

// File: rtl/pipelined_mul_unit_if.sv
// pipelined_mul_unit_if: request/response bundle of the multiply unit.
//   flush                         : kill all in-flight ops
//   in_valid/in_ready             : request handshake
//   in_a, in_b, in_op, in_sew     : operands, operation, element width
//   in_tag                        : ROB tag carried with the op
//   out_valid/out_ready           : result handshake
//   out_result, out_tag           : selected product and its tag
// Modports: master (issuing side), slave (the multiply unit).
interface pipelined_mul_unit_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 6
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [XLEN-1:0]  in_a;
  logic [XLEN-1:0]  in_b;
  logic [1:0]       in_op;
  logic [1:0]       in_sew;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_result;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output flush, in_valid, in_a, in_b, in_op, in_sew, in_tag, out_ready,
    input  in_ready, out_valid, out_result, out_tag
  );

  modport slave (
    input  flush, in_valid, in_a, in_b, in_op, in_sew, in_tag, out_ready,
    output in_ready, out_valid, out_result, out_tag
  );
endinterface

// File: rtl/pipelined_mul_unit_lane_array.sv
// mul_lane_array: combinational SEW-segmented radix-4 Booth multiplier.
// For every element width between MIN_SEW and XLEN a set of XLEN/SEW lanes
// is built; each lane extends its operands by sign/zero according to the
// op, generates Booth partial products and sums them into the exact 2*SEW
// product. Lane i's product lands at prod[i*2*SEW +: 2*SEW].
// Ports:
//   a, b : packed operands (XLEN)
//   op   : mul_op_e, selects per-operand signedness
//   sew  : element width; must be one of the built widths
//   prod : packed lane products (2*XLEN)
module mul_lane_array
  import mul_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int MIN_SEW = 8
) (
  input  logic [XLEN-1:0]   a,
  input  logic [XLEN-1:0]   b,
  input  mul_op_e           op,
  input  sew_e              sew,
  output logic [2*XLEN-1:0] prod
);

  logic a_signed;
  logic b_signed;
  assign a_signed = (op == OP_MULH) || (op == OP_MULHSU);
  assign b_signed = (op == OP_MULH);

  logic [2*XLEN-1:0] prod_by_sew [4];

  genvar gi, gj;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_sew
      localparam int W = 8 << gi;
      if (W >= MIN_SEW && W <= XLEN) begin : g_on
        logic [2*XLEN-1:0] lanes;
        for (gj = 0; gj < XLEN / W; gj++) begin : g_lane
          // Booth digits over the (W+2)-bit extended multiplier; the two
          // extra bits carry the sign (or zero) so the count stays even.
          localparam int D = (W + 2) / 2;
          logic [W-1:0]   a_lane;
          logic [W-1:0]   b_lane;
          logic [2*W-1:0] x;
          logic [W+2:0]   ystr;
          logic [2*W-1:0] acc;

          assign a_lane = a[gj*W +: W];
          assign b_lane = b[gj*W +: W];
          assign x      = {{W{a_signed & a_lane[W-1]}}, a_lane};
          // Implicit y[-1] = 0 appended at the bottom.
          assign ystr   = {{2{b_signed & b_lane[W-1]}}, b_lane, 1'b0};

          always_comb begin
            logic [2:0]     grp;
            logic [2*W-1:0] pp;
            acc = '0;
            grp = '0;
            pp  = '0;
            for (int j = 0; j < D; j++) begin
              grp = ystr[2*j +: 3];
              case (grp)
                3'b001, 3'b010: pp = x;
                3'b011:         pp = x << 1;
                3'b100:         pp = -(x << 1);
                3'b101, 3'b110: pp = -x;
                default:        pp = '0;
              endcase
              // Only the low 2W bits of the exact product are needed, so
              // modular accumulation is sufficient.
              acc = acc + (pp << (2 * j));
            end
          end

          assign lanes[gj*2*W +: 2*W] = acc;
        end
        assign prod_by_sew[gi] = lanes;
      end else begin : g_off
        assign prod_by_sew[gi] = '0;
      end
    end
  endgenerate

  always_comb prod = prod_by_sew[sew];

endmodule

// File: rtl/pipelined_mul_unit.sv
// pipelined_mul_unit: fully pipelined integer multiplier, one op per cycle.
// Stage 0 registers the Booth product; stages 1..MUL_LATENCY-1 carry it
// (reduction depth is left to register retiming). The last stage selects
// the low/high half per lane. Valid/tag/op/sew travel with each product.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : pipelined_mul_unit_if.slave (handshakes, operands, flush)
// Build option: MUL_SIMD_EN enables packed SEW 8/16/32/64 lanes; without
// it in_sew is ignored and a single XLEN-wide lane is built.
module pipelined_mul_unit
  import mul_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int MUL_LATENCY = 4,
  parameter int TAG_W       = 6
) (
  input logic                  clk,
  input logic                  rst_n,
  pipelined_mul_unit_if.slave  bus
);

  localparam int   LAST     = MUL_LATENCY - 1;
  localparam sew_e XLEN_SEW = (XLEN == 64) ? SEW_64 : SEW_32;

  mul_op_e op_in;
  sew_e    sew_in;
  assign op_in = mul_op_e'(bus.in_op);

`ifdef MUL_SIMD_EN
  localparam int MIN_SEW = 8;
  sew_e sew_raw;
  assign sew_raw = sew_e'(bus.in_sew);
  // Widths wider than XLEN collapse to XLEN.
  assign sew_in  = (sew_bits(sew_raw) > XLEN) ? XLEN_SEW : sew_raw;
`else
  localparam int MIN_SEW = XLEN;
  assign sew_in = XLEN_SEW;
`endif

  logic [2*XLEN-1:0] prod_comb;

  mul_lane_array #(
    .XLEN    (XLEN),
    .MIN_SEW (MIN_SEW)
  ) u_lanes (
    .a    (bus.in_a),
    .b    (bus.in_b),
    .op   (op_in),
    .sew  (sew_in),
    .prod (prod_comb)
  );

  logic              valid_reg [MUL_LATENCY];
  logic [TAG_W-1:0]  tag_reg   [MUL_LATENCY];
  mul_op_e           op_reg    [MUL_LATENCY];
  sew_e              sew_reg   [MUL_LATENCY];
  logic [2*XLEN-1:0] prod_reg  [MUL_LATENCY];

  // Whole pipeline moves together; a held output freezes every stage,
  // bubbles included.
  logic advance;
  assign advance      = !bus.flush && (!valid_reg[LAST] || bus.out_ready);
  assign bus.in_ready = advance;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MUL_LATENCY; i++) begin
        valid_reg[i] <= 1'b0;
        tag_reg[i]   <= '0;
        op_reg[i]    <= OP_MUL;
        sew_reg[i]   <= XLEN_SEW;
        prod_reg[i]  <= '0;
      end
    end else if (bus.flush) begin
      for (int i = 0; i < MUL_LATENCY; i++) begin
        valid_reg[i] <= 1'b0;
      end
    end else if (advance) begin
      valid_reg[0] <= bus.in_valid;
      tag_reg[0]   <= bus.in_tag;
      op_reg[0]    <= op_in;
      sew_reg[0]   <= sew_in;
      prod_reg[0]  <= prod_comb;
      for (int i = 1; i < MUL_LATENCY; i++) begin
        valid_reg[i] <= valid_reg[i-1];
        tag_reg[i]   <= tag_reg[i-1];
        op_reg[i]    <= op_reg[i-1];
        sew_reg[i]   <= sew_reg[i-1];
        prod_reg[i]  <= prod_reg[i-1];
      end
    end
  end

  // Final-stage half select per lane, one candidate per element width.
  logic [XLEN-1:0] res_by_sew [4];

  genvar gi, gj;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_sel
      localparam int W = 8 << gi;
      if (W <= XLEN) begin : g_on
        logic [XLEN-1:0] lanes;
        for (gj = 0; gj < XLEN / W; gj++) begin : g_lane
          assign lanes[gj*W +: W] = (op_reg[LAST] == OP_MUL)
                                    ? prod_reg[LAST][gj*2*W +: W]
                                    : prod_reg[LAST][gj*2*W + W +: W];
        end
        assign res_by_sew[gi] = lanes;
      end else begin : g_off
        assign res_by_sew[gi] = '0;
      end
    end
  endgenerate

  assign bus.out_valid  = valid_reg[LAST];
  assign bus.out_tag    = tag_reg[LAST];
  assign bus.out_result = res_by_sew[sew_reg[LAST]];

endmodule
